rs_param: RTL and testbench
===========================

RS_PARAM -- requirements
Module: rs_param

Interface
REQ-001 Parameter DEPTH, default 16: entry count, power of 2, 2..64.
REQ-002 Parameter TAG_W, default 4: ROB tag width; tag 0 means operand resolved / no tag.
REQ-003 Parameter DATA_W, default 32; OP_W, default 6; NCDB, default 3 (number of broadcast channels).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rdy  in  1  global enable; when 0, no state changes.
REQ-007 flush  in  1  misbranch; drops all entries and output.
REQ-008 in_valid  in  1; in_ready  out  1  dispatch handshake.
REQ-009 in_op OP_W, in_rob_tag TAG_W, in_v1/in_v2/in_imm/in_pc DATA_W, in_q1/in_q2 TAG_W  in  dispatched entry fields.
REQ-010 cdb_valid  in  NCDB; cdb_tag  in  NCDB*TAG_W; cdb_value  in  NCDB*DATA_W  (channel k at slice k).
REQ-011 out_valid  out  1; out_ready  in  1  issue handshake to ALU.
REQ-012 out_op/out_rob_tag/out_v1/out_v2/out_imm/out_pc  out  registered issue payload.
REQ-013 count  out  clog2(DEPTH)+1  busy entry count.

Function
REQ-014 Dispatch fires on in_valid & in_ready & rdy & ~flush; in_ready = rdy & (count < DEPTH), from registered state only (same-cycle issue does not raise it).
REQ-015 Dispatch writes lowest-index free entry; busy set; age = 0; every other busy entry's age increments by 1.
REQ-016 Dispatch forwarding: if cdb_valid[k] and cdb_tag[k] == in_q1 (nonzero), entry stores cdb_value[k] as v1 with q1 = 0; same for q2.
REQ-017 Wakeup: each busy entry with nonzero q1 matching a valid channel takes that value, q1 <= 0; same for q2; both operands may wake in one cycle.
REQ-018 Multiple valid channels with equal tag: lowest channel index wins.
REQ-019 Entry eligible when busy & q1 == 0 & q2 == 0, evaluated on registered state.
REQ-020 Selection: eligible entry with largest age (oldest); ages of busy entries are always distinct.
REQ-021 Output register loads when ~out_valid | out_ready; on load with an eligible entry: payload copied, out_valid <= 1, entry busy cleared same edge; with no eligible entry: out_valid <= 0.
REQ-022 out_valid and payload held stable while out_valid & ~out_ready.
REQ-023 Latency: operands resolved at dispatch edge E -> out_valid high after edge E+1; CDB wakeup at edge E -> out_valid after E+1 at earliest.
REQ-024 Dispatch and issue in the same cycle both take effect; count = count + dispatch - issue.
REQ-025 Full: count == DEPTH -> in_ready = 0; issue still proceeds.
REQ-026 Empty: no eligible entry -> out_valid drops after the current output is accepted.
REQ-027 flush (with rdy): all busy <= 0, out_valid <= 0, count <= 0; concurrent dispatch and CDB ignored.
REQ-028 rdy == 0: all registers hold, including out_valid; in_ready = 0.
REQ-029 Age counters width clog2(DEPTH); never overflow, since at most DEPTH-1 other entries exist.

Reset
REQ-030 rst low asynchronously: all busy = 0, count = 0, out_valid = 0, out_op = 0, out_rob_tag = 0, other payload = 0; entry data contents don't-care.
REQ-031 rst deassertion mid-operation: first active edge behaves as empty station; no stale issue.

Verification
REQ-032 Dispatch op=ADD, tag 3, q1=q2=0, out_ready=1 -> out_valid after 2nd edge, out_rob_tag=3, count back to 0.
REQ-033 Dispatch tag 5 with q1=2; two cycles later CDB ch1 tag 2 value 0x1234 -> out_v1 = 0x1234 one edge after wakeup+1; no issue before.
REQ-034 Dispatch tags 4, 6 (both waiting on tag 9), then broadcast 9 -> tag 4 issues first, tag 6 next cycle.
REQ-035 Fill DEPTH entries with unresolved operands -> in_ready = 0, count = DEPTH; wake one -> issue then in_ready = 1 next cycle.
REQ-036 out_ready held 0 for 3 cycles with out_valid=1 -> payload stable, entries retained; flush asserted -> out_valid = 0, count = 0 next edge.
REQ-037 Dispatch with in_q2=7 while CDB ch0 and ch2 carry tag 7 (values 0xA, 0xB) -> stored v2 = 0xA, q2 = 0.

Source files
------------

// File: rtl/rs_param_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_param_if
// Description : Dispatch, CDB broadcast and issue bundle of the reservation
//               station. Master is the pipeline side, slave is the station.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_param_if #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int NCDB   = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     rdy;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [OP_W-1:0]          in_op;
  logic [TAG_W-1:0]         in_rob_tag;
  logic [DATA_W-1:0]        in_v1;
  logic [DATA_W-1:0]        in_v2;
  logic [DATA_W-1:0]        in_imm;
  logic [DATA_W-1:0]        in_pc;
  logic [TAG_W-1:0]         in_q1;
  logic [TAG_W-1:0]         in_q2;
  logic [NCDB-1:0]          cdb_valid;
  logic [NCDB*TAG_W-1:0]    cdb_tag;
  logic [NCDB*DATA_W-1:0]   cdb_value;
  logic                     out_valid;
  logic                     out_ready;
  logic [OP_W-1:0]          out_op;
  logic [TAG_W-1:0]         out_rob_tag;
  logic [DATA_W-1:0]        out_v1;
  logic [DATA_W-1:0]        out_v2;
  logic [DATA_W-1:0]        out_imm;
  logic [DATA_W-1:0]        out_pc;
  logic [CNT_W-1:0]         count;

  modport master (
    output rdy, flush, in_valid, in_op, in_rob_tag, in_v1, in_v2, in_imm,
           in_pc, in_q1, in_q2, cdb_valid, cdb_tag, cdb_value, out_ready,
    input  in_ready, out_valid, out_op, out_rob_tag, out_v1, out_v2,
           out_imm, out_pc, count
  );

  modport slave (
    input  rdy, flush, in_valid, in_op, in_rob_tag, in_v1, in_v2, in_imm,
           in_pc, in_q1, in_q2, cdb_valid, cdb_tag, cdb_value, out_ready,
    output in_ready, out_valid, out_op, out_rob_tag, out_v1, out_v2,
           out_imm, out_pc, count
  );
endinterface
`default_nettype wire

// File: rtl/rs_param.sv
`default_nettype none
// ============================================================================
// Module      : rs_param
// Description : Parameterised reservation station. Entries wait for their
//               operands on the CDB and issue oldest-ready-first through a
//               registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_param #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int NCDB   = 3
) (
  input  wire logic  clk,
  input  wire logic  rst,
  rs_param_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AGE_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Returns {hit, value}; the scan runs high-to-low so the lowest channel wins.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]       q,
    input logic [NCDB-1:0]        vld,
    input logic [NCDB*TAG_W-1:0]  tags,
    input logic [NCDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    if (q != '0) begin
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (vld[k] && (tags[k*TAG_W +: TAG_W] == q))
          res = {1'b1, vals[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  logic [DEPTH-1:0]  r_busy;
  logic [AGE_W-1:0]  r_age [DEPTH];
  logic [OP_W-1:0]   r_op  [DEPTH];
  logic [TAG_W-1:0]  r_rob [DEPTH];
  logic [DATA_W-1:0] r_v1  [DEPTH];
  logic [DATA_W-1:0] r_v2  [DEPTH];
  logic [DATA_W-1:0] r_imm [DEPTH];
  logic [DATA_W-1:0] r_pc  [DEPTH];
  logic [TAG_W-1:0]  r_q1  [DEPTH];
  logic [TAG_W-1:0]  r_q2  [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic              r_out_valid;
  logic [OP_W-1:0]   r_out_op;
  logic [TAG_W-1:0]  r_out_rob;
  logic [DATA_W-1:0] r_out_v1;
  logic [DATA_W-1:0] r_out_v2;
  logic [DATA_W-1:0] r_out_imm;
  logic [DATA_W-1:0] r_out_pc;

  logic [DATA_W:0]   w_wake1 [DEPTH];
  logic [DATA_W:0]   w_wake2 [DEPTH];
  logic [DATA_W:0]   w_fwd1;
  logic [DATA_W:0]   w_fwd2;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [AGE_W-1:0]  w_sel_age;
  logic              w_any_elig;
  logic              w_in_ready;
  logic              w_disp;
  logic              w_load;
  logic              w_issue;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_wake1[i] = cdb_match(r_q1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    assign w_wake2[i] = cdb_match(r_q2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  end

  assign w_fwd1 = cdb_match(bus.in_q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  assign w_fwd2 = cdb_match(bus.in_q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

  // Lowest free slot for dispatch and oldest ready entry for issue.
  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    w_sel_idx    = '0;
    w_sel_age    = '0;
    w_any_elig   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_busy[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0) &&
          (!w_any_elig || (r_age[i] > w_sel_age))) begin
        w_any_elig = 1'b1;
        w_sel_idx  = IDX_W'(i);
        w_sel_age  = r_age[i];
      end
    end
  end

  // in_ready looks only at the registered count, never at a same-cycle issue.
  assign w_in_ready = bus.rdy && (r_count < CNT_W'(DEPTH));
  assign w_disp     = bus.in_valid && w_in_ready && !bus.flush;
  assign w_load     = !r_out_valid || bus.out_ready;
  assign w_issue    = bus.rdy && !bus.flush && w_load && w_any_elig;

  // Occupancy and age bookkeeping. Ages are kept as a rank among busy
  // entries: dispatch bumps everyone, issue closes the gap above the issued
  // entry, so ages stay distinct and never exceed DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        r_busy  <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i]) begin
            if (w_issue && (w_sel_idx == IDX_W'(i)))
              r_busy[i] <= 1'b0;
            else
              r_age[i] <= r_age[i] + AGE_W'(w_disp)
                          - AGE_W'(w_issue && (r_age[i] > w_sel_age));
          end
        end
        if (w_disp) begin
          r_busy[w_free_idx] <= 1'b1;
          r_age[w_free_idx]  <= '0;
        end
        r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
      end
    end
  end

  // Entry payload: operand wakeup from the CDB and dispatch write with forwarding.
  always_ff @(posedge clk) begin
    if (bus.rdy && !bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i]) begin
          if (w_wake1[i][DATA_W]) begin
            r_v1[i] <= w_wake1[i][DATA_W-1:0];
            r_q1[i] <= '0;
          end
          if (w_wake2[i][DATA_W]) begin
            r_v2[i] <= w_wake2[i][DATA_W-1:0];
            r_q2[i] <= '0;
          end
        end
      end
      if (w_disp) begin
        r_op[w_free_idx]  <= bus.in_op;
        r_rob[w_free_idx] <= bus.in_rob_tag;
        r_imm[w_free_idx] <= bus.in_imm;
        r_pc[w_free_idx]  <= bus.in_pc;
        r_v1[w_free_idx]  <= w_fwd1[DATA_W] ? w_fwd1[DATA_W-1:0] : bus.in_v1;
        r_q1[w_free_idx]  <= w_fwd1[DATA_W] ? '0 : bus.in_q1;
        r_v2[w_free_idx]  <= w_fwd2[DATA_W] ? w_fwd2[DATA_W-1:0] : bus.in_v2;
        r_q2[w_free_idx]  <= w_fwd2[DATA_W] ? '0 : bus.in_q2;
      end
    end
  end

  // Issue register: reloads when empty or accepted, holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_rob   <= '0;
      r_out_v1    <= '0;
      r_out_v2    <= '0;
      r_out_imm   <= '0;
      r_out_pc    <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= w_any_elig;
        if (w_any_elig) begin
          r_out_op  <= r_op[w_sel_idx];
          r_out_rob <= r_rob[w_sel_idx];
          r_out_v1  <= r_v1[w_sel_idx];
          r_out_v2  <= r_v2[w_sel_idx];
          r_out_imm <= r_imm[w_sel_idx];
          r_out_pc  <= r_pc[w_sel_idx];
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.count       = r_count;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_op      = r_out_op;
  assign bus.out_rob_tag = r_out_rob;
  assign bus.out_v1      = r_out_v1;
  assign bus.out_v2      = r_out_v2;
  assign bus.out_imm     = r_out_imm;
  assign bus.out_pc      = r_out_pc;
endmodule
`default_nettype wire

// File: tb/tb_rs_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_param
// Description : Directed bench for rs_param with an issue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_param;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int NCDB   = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  rs_param_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .NCDB(NCDB)) bus ();

  rs_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .NCDB(NCDB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every accepted issue is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (rst && bus.rdy && !bus.flush && bus.out_valid && bus.out_ready) begin
      got = '{bus.out_rob_tag, bus.out_op, bus.out_v1, bus.out_v2, bus.out_imm, bus.out_pc};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: got %h expected none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL issue_payload: got %h expected %h", got, want);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.cdb_valid = '0;
  endtask

  task automatic dispatch(input logic [TAG_W-1:0] tag, input logic [OP_W-1:0] op,
                          input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] q1,
                          input logic [DATA_W-1:0] v2, input logic [TAG_W-1:0] q2,
                          input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc);
    bus.in_valid   = 1'b1;
    bus.in_rob_tag = tag;
    bus.in_op      = op;
    bus.in_v1      = v1;
    bus.in_q1      = q1;
    bus.in_v2      = v2;
    bus.in_q2      = q2;
    bus.in_imm     = imm;
    bus.in_pc      = pc;
  endtask

  task automatic cdb(input int ch, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    bus.cdb_valid[ch]                 = 1'b1;
    bus.cdb_tag[ch*TAG_W +: TAG_W]    = tag;
    bus.cdb_value[ch*DATA_W +: DATA_W] = val;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.rdy  = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.cdb_tag   = '0;
    bus.cdb_value = '0;
    dispatch('0, '0, '0, '0, '0, '0, '0, '0);
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_out_rob_tag", 64'(bus.out_rob_tag), 64'd0);
    check("rst_out_op", 64'(bus.out_op), 64'd0);
    check("rst_out_v1", 64'(bus.out_v1), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;

    // Resolved dispatch issues after the second edge
    dispatch(4'd3, 6'd1, 32'd10, 4'd0, 32'd20, 4'd0, 32'd0, 32'h100);
    exp_q.push_back('{4'd3, 6'd1, 32'd10, 32'd20, 32'd0, 32'h100});
    step();
    idle();
    check("t1_count_after_disp", 64'(bus.count), 64'd1);
    check("t1_no_early_issue", 64'(bus.out_valid), 64'd0);
    step();
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_rob_tag", 64'(bus.out_rob_tag), 64'd3);
    check("t1_count_zero", 64'(bus.count), 64'd0);
    step();
    check("t1_drained", 64'(bus.out_valid), 64'd0);

    // CDB wakeup of q1 on channel 1
    dispatch(4'd5, 6'd2, 32'd0, 4'd2, 32'd7, 4'd0, 32'h5, 32'h200);
    exp_q.push_back('{4'd5, 6'd2, 32'h1234, 32'd7, 32'h5, 32'h200});
    step();
    idle();
    step();
    check("t2_wait_a", 64'(bus.out_valid), 64'd0);
    step();
    check("t2_wait_b", 64'(bus.out_valid), 64'd0);
    cdb(1, 4'd2, 32'h1234);
    step();
    idle();
    check("t2_wait_wakeup_edge", 64'(bus.out_valid), 64'd0);
    step();
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_out_v1", 64'(bus.out_v1), 64'h1234);
    step();

    // Two waiters on tag 9: older issues first
    dispatch(4'd4, 6'd3, 32'd0, 4'd9, 32'h44, 4'd0, 32'd0, 32'h300);
    exp_q.push_back('{4'd4, 6'd3, 32'h99, 32'h44, 32'd0, 32'h300});
    step();
    dispatch(4'd6, 6'd4, 32'h66, 4'd0, 32'd0, 4'd9, 32'd0, 32'h304);
    exp_q.push_back('{4'd6, 6'd4, 32'h66, 32'h99, 32'd0, 32'h304});
    step();
    idle();
    cdb(0, 4'd9, 32'h99);
    step();
    idle();
    step();
    check("t3_first_tag", 64'(bus.out_rob_tag), 64'd4);
    step();
    check("t3_second_valid", 64'(bus.out_valid), 64'd1);
    check("t3_second_tag", 64'(bus.out_rob_tag), 64'd6);
    step();

    // Dispatch forwarding with two matching channels: lowest channel wins
    dispatch(4'd8, 6'd5, 32'h11, 4'd0, 32'd0, 4'd7, 32'h8, 32'h400);
    exp_q.push_back('{4'd8, 6'd5, 32'h11, 32'hA, 32'h8, 32'h400});
    cdb(0, 4'd7, 32'hA);
    cdb(2, 4'd7, 32'hB);
    step();
    idle();
    step();
    check("t4_out_v2", 64'(bus.out_v2), 64'hA);
    step();

    // Fill the station with waiting entries
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(TAG_W'(i), 6'd6, 32'd0, (i == 0) ? 4'd1 : 4'd2, 32'(i), 4'd0, 32'd0, 32'(i));
      step();
    end
    idle();
    check("t5_count_full", 64'(bus.count), 64'(DEPTH));
    check("t5_in_ready_full", 64'(bus.in_ready), 64'd0);
    dispatch(4'd14, 6'd7, 32'd0, 4'd2, 32'd0, 4'd0, 32'd0, 32'd0);
    step();
    idle();
    check("t5_reject_when_full", 64'(bus.count), 64'(DEPTH));
    exp_q.push_back('{4'd0, 6'd6, 32'h55, 32'd0, 32'd0, 32'd0});
    cdb(2, 4'd1, 32'h55);
    step();
    idle();
    check("t5_still_full", 64'(bus.in_ready), 64'd0);
    step();
    check("t5_issue_tag", 64'(bus.out_rob_tag), 64'd0);
    check("t5_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("t5_count_after_issue", 64'(bus.count), 64'(DEPTH - 1));
    step();

    // Backpressure hold, then flush
    bus.out_ready = 1'b0;
    cdb(0, 4'd2, 32'h77);
    step();
    idle();
    step();
    for (int c = 0; c < 3; c++) begin
      check("t6_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t6_hold_tag", 64'(bus.out_rob_tag), 64'd1);
      check("t6_hold_v1", 64'(bus.out_v1), 64'h77);
      check("t6_hold_count", 64'(bus.count), 64'(DEPTH - 2));
      step();
    end
    bus.flush = 1'b1;
    dispatch(4'd15, 6'd1, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    step();
    bus.flush = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    check("t6_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t6_flush_count", 64'(bus.count), 64'd0);
    step();
    check("t6_no_issue_after_flush", 64'(bus.out_valid), 64'd0);

    // rdy low freezes everything
    dispatch(4'd10, 6'd2, 32'd1, 4'd0, 32'd2, 4'd0, 32'd3, 32'h500);
    exp_q.push_back('{4'd10, 6'd2, 32'd1, 32'd2, 32'd3, 32'h500});
    step();
    idle();
    bus.rdy = 1'b0;
    step();
    step();
    check("t7_frozen_valid", 64'(bus.out_valid), 64'd0);
    check("t7_frozen_count", 64'(bus.count), 64'd1);
    check("t7_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.rdy = 1'b1;
    step();
    check("t7_issue_tag", 64'(bus.out_rob_tag), 64'd10);
    step();

    // Dispatch and issue on the same edge
    dispatch(4'd11, 6'd3, 32'd4, 4'd0, 32'd5, 4'd0, 32'd0, 32'h600);
    exp_q.push_back('{4'd11, 6'd3, 32'd4, 32'd5, 32'd0, 32'h600});
    step();
    dispatch(4'd12, 6'd4, 32'd6, 4'd0, 32'd7, 4'd0, 32'd0, 32'h604);
    exp_q.push_back('{4'd12, 6'd4, 32'd6, 32'd7, 32'd0, 32'h604});
    step();
    idle();
    check("t8_count_concurrent", 64'(bus.count), 64'd1);
    check("t8_first_tag", 64'(bus.out_rob_tag), 64'd11);
    step();
    check("t8_second_tag", 64'(bus.out_rob_tag), 64'd12);
    check("t8_count_zero", 64'(bus.count), 64'd0);
    step();

    // Reset mid-operation drops the pending entry
    dispatch(4'd13, 6'd5, 32'd8, 4'd0, 32'd9, 4'd0, 32'd0, 32'h700);
    step();
    idle();
    rst = 1'b0;
    #1;
    check("t9_async_count", 64'(bus.count), 64'd0);
    check("t9_async_valid", 64'(bus.out_valid), 64'd0);
    step();
    rst = 1'b1;
    step();
    check("t9_no_stale_issue", 64'(bus.out_valid), 64'd0);
    check("t9_count_after", 64'(bus.count), 64'd0);
    step();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
